// File: rtl/pci_initiator.sv
// -----------------------------------------------------------------------------
// pci_initiator
//   Bus-master side of a simple PCI-style link. The local side preloads write
//   words into an internal FIFO, then issues one burst request (cmd, addr, len).
//   The block runs the address phase, then one data phase per word, and ends
//   with a one-cycle turnaround. Read data comes back one word per completed
//   phase on rd_data/rd_valid.
//
// Ports
//   clk, reset            bus clock (rising edge), async active-high reset
//   Frame, IRDY           active-low bus controls driven by this block
//   AD_Line               shared address/data bus (driven only in ADDR and
//                         write data phases, otherwise released to Z)
//   C_BE                  command in ADDR, byte enables in data phases, Z idle
//   TRDY, Dev_Sel         active-low target responses
//   start/cmd/addr/len/be burst request, captured on start while idle
//   local_wait            holds IRDY high in DATA (initiator wait state)
//   wr_data/wr_push       write FIFO input; wr_full/wr_count report occupancy
//   rd_data/rd_valid      read word and its one-cycle strobe
//   busy/done/err         status; done and err are one-cycle pulses
//   state_dbg             current FSM state for observation
//
// Handshake: a data phase completes on a rising edge where IRDY=0 and TRDY=0
// are both sampled; only then is a write word popped or a read word captured.
// rd_valid has no backpressure, and start is only honoured while busy=0.
// -----------------------------------------------------------------------------
module pci_initiator #(
  parameter int MAX_BURST      = 16,
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int LEN_W          = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             Frame,
  output logic             IRDY,
  inout  wire  [31:0]      AD_Line,
  output logic [3:0]       C_BE,
  input  logic             TRDY,
  input  logic             Dev_Sel,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       be,
  input  logic             local_wait,
  input  logic [31:0]      wr_data,
  input  logic             wr_push,
  output logic             wr_full,
  output logic [LEN_W-1:0] wr_count,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  localparam logic [3:0] CMD_RD = 4'b0110;
  localparam logic [3:0] CMD_WR = 4'b0111;
  localparam int PTR_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int DCNT_W = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ABORT = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               dsel_q, dsel_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [MAX_BURST];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic               is_wr;
  logic               req_bad;
  logic               abort_now;
  logic               phase_done;
  logic               push_ok;
  logic               pop;

  logic               ad_oe;
  logic [31:0]        ad_out;
  logic               cbe_oe;
  logic [3:0]         cbe_out;

  assign is_wr   = (cmd_q == CMD_WR);
  assign wr_full = (cnt_q == LEN_W'(MAX_BURST));
  assign push_ok = wr_push && !wr_full;

  assign req_bad = (len == '0) || (len > LEN_W'(MAX_BURST)) ||
                   ((cmd != CMD_RD) && (cmd != CMD_WR)) ||
                   ((cmd == CMD_WR) && (cnt_q < len));

  // The timeout only runs until Dev_Sel is seen once; the edge that would
  // exceed the budget aborts and takes priority over any phase completion.
  assign abort_now = (state_q == S_DATA) && !dsel_q && Dev_Sel &&
                     (dcnt_q == DCNT_W'(DEVSEL_TIMEOUT - 1));

  assign phase_done = (state_q == S_DATA) && !local_wait && !TRDY && !abort_now;
  assign pop        = phase_done && is_wr;

  // State and control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      dcnt_q     <= '0;
      dsel_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dcnt_q     <= dcnt_d;
      dsel_q     <= dsel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = (wptr_q == PTR_W'(MAX_BURST - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)     rptr_d = (rptr_q == PTR_W'(MAX_BURST - 1)) ? '0 : rptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    dcnt_d     = dcnt_q;
    dsel_d     = dsel_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ADDR;
            cmd_d   = cmd;
            addr_d  = addr;
            rem_d   = len;
          end
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        dcnt_d  = '0;
        dsel_d  = 1'b0;
      end
      S_DATA: begin
        if (!Dev_Sel)     dsel_d = 1'b1;
        else if (!dsel_q) dcnt_d = dcnt_q + 1'b1;
        if (abort_now) begin
          state_d = S_ABORT;
        end else if (phase_done) begin
          rem_d = rem_q - 1'b1;
          if (!is_wr) begin
            rd_data_d  = AD_Line;
            rd_valid_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = S_TURN;
            done_d  = 1'b1;
          end
        end
      end
      S_ABORT: begin
        state_d = S_TURN;
        err_d   = 1'b1;
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the current state so reset releases the bus
  // immediately, without waiting for a clock.
  always_comb begin
    Frame   = 1'b1;
    IRDY    = 1'b1;
    ad_oe   = 1'b0;
    ad_out  = mem_q[rptr_q];
    cbe_oe  = 1'b0;
    cbe_out = be;
    case (state_q)
      S_ADDR: begin
        Frame   = 1'b0;
        ad_oe   = 1'b1;
        ad_out  = addr_q;
        cbe_oe  = 1'b1;
        cbe_out = cmd_q;
      end
      S_DATA: begin
        Frame  = (rem_q == LEN_W'(1));
        IRDY   = local_wait;
        ad_oe  = is_wr;
        cbe_oe = 1'b1;
      end
      S_ABORT: begin
        IRDY   = 1'b0;
        ad_oe  = is_wr;
        cbe_oe = 1'b1;
      end
      default: begin
        Frame = 1'b1;
        IRDY  = 1'b1;
      end
    endcase
  end

  assign AD_Line = ad_oe  ? ad_out  : 32'bz;
  assign C_BE    = cbe_oe ? cbe_out : 4'bz;

  assign wr_count  = cnt_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pci_initiator.sv
// -----------------------------------------------------------------------------
// tb_pci_initiator
//   Directed bench for pci_initiator. Each scenario task drives a request,
//   lets run_burst step the bus with per-cycle target responses taken from
//   schedule arrays, and then compares the logged bus activity against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_pci_initiator;

  localparam int LEN_W = 5;
  localparam logic [3:0] CMD_RD = 4'b0110;
  localparam logic [3:0] CMD_WR = 4'b0111;

  // clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic             Frame, IRDY;
  wire  [31:0]      AD_Line;
  wire  [3:0]       C_BE;
  logic             TRDY, Dev_Sel, start, local_wait, wr_push;
  logic [3:0]       cmd, be;
  logic [31:0]      addr, wr_data;
  logic [LEN_W-1:0] len;
  logic             wr_full, rd_valid, busy, done, err;
  logic [LEN_W-1:0] wr_count;
  logic [31:0]      rd_data;
  logic [2:0]       state_dbg;

  // target-side driver for AD_Line
  logic        tb_drv_en;
  logic [31:0] tb_drv;
  assign AD_Line = tb_drv_en ? tb_drv : 32'bz;

  pci_initiator #(.MAX_BURST(16), .DEVSEL_TIMEOUT(5), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .Frame(Frame), .IRDY(IRDY), .AD_Line(AD_Line),
    .C_BE(C_BE), .TRDY(TRDY), .Dev_Sel(Dev_Sel), .start(start), .cmd(cmd),
    .addr(addr), .len(len), .be(be), .local_wait(local_wait), .wr_data(wr_data),
    .wr_push(wr_push), .wr_full(wr_full), .wr_count(wr_count), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // counters
  int n_tests = 0;
  int n_fail  = 0;

  // per-cycle target schedule, indexed from the ADDR cycle (c = 0)
  logic        trdy_s [64];
  logic        lw_s   [64];
  logic        ds_s   [64];
  logic        push_s [64];
  logic [31:0] push_d [64];

  // per-cycle logs and burst statistics
  logic        frame_log [64];
  logic        irdy_log  [64];
  logic [31:0] ad_log    [64];
  logic [3:0]  cbe_log   [64];
  logic [4:0]  wcnt_log  [64];
  int          cycles, n_frame_low, n_done, n_err, n_cpl, n_ad_conflict;
  logic [31:0] rd_got  [$];
  logic [31:0] wr_seen [$];

  // ---------------------------------------------------------------- drivers
  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      trdy_s[i] = 1'b0; lw_s[i] = 1'b0; ds_s[i] = 1'b0;
      push_s[i] = 1'b0; push_d[i] = '0;
    end
  endtask

  task automatic push1(input logic [31:0] v);
    @(posedge clk); #1;
    wr_push = 1'b1; wr_data = v;
  endtask

  task automatic push_end();
    @(posedge clk); #1;
    wr_push = 1'b0;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [LEN_W-1:0] l, input logic [3:0] b);
    @(posedge clk); #1;
    wr_push = 1'b0; start = 1'b1; cmd = c; addr = a; len = l; be = b;
    TRDY = trdy_s[0]; Dev_Sel = ds_s[0]; local_wait = lw_s[0];
  endtask

  // Steps the bus until busy drops (or max_cyc), acting as the target.
  task automatic run_burst(input int max_cyc, input bit rd);
    int c;
    c = 0;
    n_frame_low = 0; n_done = 0; n_err = 0; n_cpl = 0; n_ad_conflict = 0;
    rd_got.delete(); wr_seen.delete();
    while (c < max_cyc) begin
      @(posedge clk); #1;
      start      = 1'b0;
      TRDY       = trdy_s[c];
      local_wait = lw_s[c];
      Dev_Sel    = ds_s[c];
      wr_push    = push_s[c];
      wr_data    = push_d[c];
      tb_drv_en  = rd && (c >= 1);
      tb_drv     = 32'hA0 + 32'(n_cpl);
      #1;
      if (!busy) break;
      frame_log[c] = Frame;
      irdy_log[c]  = IRDY;
      ad_log[c]    = AD_Line;
      cbe_log[c]   = C_BE;
      wcnt_log[c]  = wr_count;
      if (!Frame)   n_frame_low++;
      if (done)     n_done++;
      if (err)      n_err++;
      if (rd_valid) rd_got.push_back(rd_data);
      if (rd && c >= 1 && AD_Line !== tb_drv) n_ad_conflict++;
      if (c >= 1 && IRDY === 1'b0 && TRDY === 1'b0) begin
        n_cpl++;
        if (!rd) wr_seen.push_back(AD_Line);
      end
      c++;
    end
    cycles    = c;
    tb_drv_en = 1'b0;
    wr_push   = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cmd = '0; addr = '0; len = '0; be = '0;
    TRDY = 1'b1; Dev_Sel = 1'b1; local_wait = 1'b0; wr_push = 1'b0; wr_data = '0;
    tb_drv_en = 1'b0; tb_drv = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (Frame !== 1'b1) begin n_fail++; $display("FAIL reset_frame got=%b exp=1", Frame); end
    n_tests++; if (IRDY !== 1'b1) begin n_fail++; $display("FAIL reset_irdy got=%b exp=1", IRDY); end
    n_tests++; if ({busy, done, err, rd_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", {busy, done, err, rd_valid}); end
    n_tests++; if (wr_count !== 5'd0) begin n_fail++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    n_tests++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    tb_drv_en = 1'b1; tb_drv = 32'h5A5A_5A5A; #1;
    n_tests++; if (AD_Line !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL reset_ad_released got=%h exp=5a5a5a5a", AD_Line); end
    tb_drv_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_request_errors();
    logic [3:0]       v_cmd [4];
    logic [LEN_W-1:0] v_len [4];
    v_cmd[0] = CMD_RD;  v_len[0] = 5'd0;
    v_cmd[1] = CMD_RD;  v_len[1] = 5'd17;
    v_cmd[2] = 4'b0010; v_len[2] = 5'd1;
    v_cmd[3] = CMD_WR;  v_len[3] = 5'd1;  // FIFO is empty
    clear_sched();
    for (int i = 0; i < 4; i++) begin
      issue(v_cmd[i], 32'h0, v_len[i], 4'hF);
      @(posedge clk); #1; start = 1'b0; #1;
      n_tests++; if ({err, busy, Frame} !== 3'b101) begin n_fail++; $display("FAIL req_err_%0d got err,busy,frame=%b exp=101", i, {err, busy, Frame}); end
      @(posedge clk); #2;
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL req_err_pulse_%0d got=%b exp=0", i, err); end
    end
  endtask

  task automatic test_write_burst();
    clear_sched();
    push1(32'd4); push1(32'd8); push1(32'd16); push1(32'd32); push_end(); #1;
    n_tests++; if (wr_count !== 5'd4) begin n_fail++; $display("FAIL wr_fill got=%0d exp=4", wr_count); end
    issue(CMD_WR, 32'h0, 5'd4, 4'hF);
    run_burst(20, 1'b0);
    n_tests++; if (cycles !== 6) begin n_fail++; $display("FAIL wr_cycles got=%0d exp=6", cycles); end
    n_tests++; if (n_frame_low !== 4) begin n_fail++; $display("FAIL wr_frame_low got=%0d exp=4", n_frame_low); end
    n_tests++; if (ad_log[0] !== 32'h0 || cbe_log[0] !== CMD_WR) begin n_fail++; $display("FAIL wr_addr_phase got ad=%h cbe=%h exp ad=0 cbe=7", ad_log[0], cbe_log[0]); end
    n_tests++; if (cbe_log[1] !== 4'hF) begin n_fail++; $display("FAIL wr_be got=%h exp=f", cbe_log[1]); end
    n_tests++; if (wr_seen.size() !== 4) begin n_fail++; $display("FAIL wr_phases got=%0d exp=4", wr_seen.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (wr_seen[i] !== (32'd4 << i)) begin n_fail++; $display("FAIL wr_data_%0d got=%h exp=%h", i, wr_seen[i], 32'd4 << i); end
    end
    n_tests++; if (n_done !== 1 || n_err !== 0) begin n_fail++; $display("FAIL wr_done_err got done=%0d err=%0d exp 1/0", n_done, n_err); end
    n_tests++; if (wr_count !== 5'd0) begin n_fail++; $display("FAIL wr_drained got=%0d exp=0", wr_count); end
  endtask

  task automatic test_read_burst();
    clear_sched();
    issue(CMD_RD, 32'h0, 5'd5, 4'h3);
    run_burst(20, 1'b1);
    n_tests++; if (cycles !== 7) begin n_fail++; $display("FAIL rd_cycles got=%0d exp=7", cycles); end
    n_tests++; if (cbe_log[0] !== CMD_RD || cbe_log[2] !== 4'h3) begin n_fail++; $display("FAIL rd_cbe got %h/%h exp 6/3", cbe_log[0], cbe_log[2]); end
    n_tests++; if (frame_log[4] !== 1'b0 || frame_log[5] !== 1'b1) begin n_fail++; $display("FAIL rd_last_frame got %b%b exp 01", frame_log[4], frame_log[5]); end
    n_tests++; if (n_ad_conflict !== 0) begin n_fail++; $display("FAIL rd_ad_released got=%0d conflicts exp=0", n_ad_conflict); end
    n_tests++; if (rd_got.size() !== 5) begin n_fail++; $display("FAIL rd_count got=%0d exp=5", rd_got.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rd_got[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL rd_data_%0d got=%h exp=%h", i, rd_got[i], 32'hA0 + 32'(i)); end
    end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL rd_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_read_wait();
    clear_sched();
    lw_s[2] = 1'b1;
    issue(CMD_RD, 32'h1234_0000, 5'd4, 4'hF);
    run_burst(20, 1'b1);
    n_tests++; if (cycles !== 7) begin n_fail++; $display("FAIL rdw_cycles got=%0d exp=7", cycles); end
    n_tests++; if (ad_log[0] !== 32'h1234_0000) begin n_fail++; $display("FAIL rdw_addr got=%h exp=12340000", ad_log[0]); end
    n_tests++; if (irdy_log[2] !== 1'b1 || irdy_log[3] !== 1'b0) begin n_fail++; $display("FAIL rdw_irdy got %b%b exp 10", irdy_log[2], irdy_log[3]); end
    n_tests++; if (n_ad_conflict !== 0) begin n_fail++; $display("FAIL rdw_ad_released got=%0d conflicts exp=0", n_ad_conflict); end
    n_tests++; if (rd_got.size() !== 4) begin n_fail++; $display("FAIL rdw_count got=%0d exp=4", rd_got.size()); end
    n_tests++; if (rd_got[1] !== 32'hA1 || rd_got[3] !== 32'hA3) begin n_fail++; $display("FAIL rdw_data got %h/%h exp a1/a3", rd_got[1], rd_got[3]); end
  endtask

  task automatic test_write_wait();
    clear_sched();
    trdy_s[2] = 1'b1; trdy_s[3] = 1'b1;
    push1(32'h11); push1(32'h22); push1(32'h33); push_end();
    issue(CMD_WR, 32'h40, 5'd3, 4'hF);
    run_burst(20, 1'b0);
    n_tests++; if (cycles !== 7) begin n_fail++; $display("FAIL wrw_cycles got=%0d exp=7", cycles); end
    n_tests++; if (wcnt_log[0] !== 5'd3 || wcnt_log[3] !== 5'd2 || wcnt_log[6] !== 5'd0) begin n_fail++; $display("FAIL wrw_count got %0d/%0d/%0d exp 3/2/0", wcnt_log[0], wcnt_log[3], wcnt_log[6]); end
    n_tests++; if (wr_seen.size() !== 3) begin n_fail++; $display("FAIL wrw_phases got=%0d exp=3", wr_seen.size()); end
    n_tests++; if (wr_seen[0] !== 32'h11 || wr_seen[1] !== 32'h22 || wr_seen[2] !== 32'h33) begin n_fail++; $display("FAIL wrw_data got %h/%h/%h exp 11/22/33", wr_seen[0], wr_seen[1], wr_seen[2]); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL wrw_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_push_pop();
    clear_sched();
    push_s[1] = 1'b1; push_d[1] = 32'hCC;
    push1(32'hAA); push1(32'hBB); push_end();
    issue(CMD_WR, 32'h80, 5'd1, 4'hF);
    run_burst(20, 1'b0);
    n_tests++; if (cycles !== 3) begin n_fail++; $display("FAIL pp_cycles got=%0d exp=3", cycles); end
    n_tests++; if (frame_log[1] !== 1'b1) begin n_fail++; $display("FAIL pp_len1_frame got=%b exp=1", frame_log[1]); end
    n_tests++; if (wr_seen[0] !== 32'hAA) begin n_fail++; $display("FAIL pp_data got=%h exp=aa", wr_seen[0]); end
    n_tests++; if (wcnt_log[2] !== 5'd2) begin n_fail++; $display("FAIL pp_count got=%0d exp=2", wcnt_log[2]); end
  endtask

  task automatic test_abort();
    clear_sched();
    for (int i = 0; i < 64; i++) begin ds_s[i] = 1'b1; trdy_s[i] = 1'b1; end
    issue(CMD_WR, 32'h0, 5'd2, 4'hF);
    run_burst(20, 1'b0);
    n_tests++; if (cycles !== 8) begin n_fail++; $display("FAIL ab_cycles got=%0d exp=8", cycles); end
    n_tests++; if (n_frame_low !== 6) begin n_fail++; $display("FAIL ab_frame_low got=%0d exp=6", n_frame_low); end
    n_tests++; if (frame_log[6] !== 1'b1 || irdy_log[6] !== 1'b0 || irdy_log[7] !== 1'b1) begin n_fail++; $display("FAIL ab_bus got f6=%b i6=%b i7=%b exp 1/0/1", frame_log[6], irdy_log[6], irdy_log[7]); end
    n_tests++; if (ad_log[1] !== 32'hBB) begin n_fail++; $display("FAIL ab_head got=%h exp=bb", ad_log[1]); end
    n_tests++; if (n_err !== 1 || n_done !== 0) begin n_fail++; $display("FAIL ab_err_done got err=%0d done=%0d exp 1/0", n_err, n_done); end
    n_tests++; if (wr_count !== 5'd2) begin n_fail++; $display("FAIL ab_fifo_kept got=%0d exp=2", wr_count); end
  endtask

  task automatic test_reset_mid();
    clear_sched();
    push1(32'h1); push1(32'h2); push_end();
    issue(CMD_WR, 32'h0, 5'd4, 4'hF);
    @(posedge clk); #1; start = 1'b0;   // ADDR
    @(posedge clk); #1;                 // phase 1
    @(posedge clk); #2;                 // phase 2
    n_tests++; if (Frame !== 1'b0 || wr_count !== 5'd3) begin n_fail++; $display("FAIL rm_pre got frame=%b cnt=%0d exp 0/3", Frame, wr_count); end
    reset = 1'b1; #1;
    n_tests++; if ({Frame, IRDY, busy} !== 3'b110) begin n_fail++; $display("FAIL rm_bus got frame,irdy,busy=%b exp=110", {Frame, IRDY, busy}); end
    n_tests++; if (wr_count !== 5'd0 || rd_data !== 32'h0) begin n_fail++; $display("FAIL rm_flush got cnt=%0d rd=%h exp 0/0", wr_count, rd_data); end
    tb_drv_en = 1'b1; tb_drv = 32'h5A5A_5A5A; #1;
    n_tests++; if (AD_Line !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL rm_ad_released got=%h exp=5a5a5a5a", AD_Line); end
    tb_drv_en = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    issue(CMD_WR, 32'h0, 5'd0, 4'hF);
    @(posedge clk); #1; start = 1'b0; #1;
    n_tests++; if ({err, Frame, busy} !== 3'b110) begin n_fail++; $display("FAIL rm_len0 got err,frame,busy=%b exp=110", {err, Frame, busy}); end
  endtask

  task automatic test_fifo_full();
    clear_sched();
    for (int i = 0; i < 17; i++) push1(32'(i));
    push_end(); #1;
    n_tests++; if (wr_count !== 5'd16 || wr_full !== 1'b1) begin n_fail++; $display("FAIL full got cnt=%0d full=%b exp 16/1", wr_count, wr_full); end
    issue(CMD_WR, 32'h100, 5'd16, 4'hF);
    run_burst(40, 1'b0);
    n_tests++; if (cycles !== 18) begin n_fail++; $display("FAIL full_cycles got=%0d exp=18", cycles); end
    n_tests++; if (wr_seen.size() !== 16) begin n_fail++; $display("FAIL full_phases got=%0d exp=16", wr_seen.size()); end
    n_tests++; if (wr_seen[0] !== 32'd0 || wr_seen[15] !== 32'd15) begin n_fail++; $display("FAIL full_data got %h/%h exp 0/f", wr_seen[0], wr_seen[15]); end
    n_tests++; if (wr_count !== 5'd0 || wr_full !== 1'b0) begin n_fail++; $display("FAIL full_drained got cnt=%0d full=%b exp 0/0", wr_count, wr_full); end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_request_errors();
    test_write_burst();
    test_read_burst();
    test_read_wait();
    test_write_wait();
    test_push_pop();
    test_abort();
    test_reset_mid();
    test_fifo_full();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the test sequence");
    $fatal(1);
  end

endmodule
